// File: rtl/seg_pkg.sv
// Shared constants and types for the BCD seven-segment driver.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

  typedef logic [3:0] bcd_digit_t;

  // Index 0 is the rightmost element of the concatenation
  localparam logic [9:0][6:0] SEG_CODES = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Non-decimal nibbles (>9) decode to a blank digit.
module bcd_to_seg
  import seg_pkg::*;
(
  input  bcd_digit_t digit,
  output logic [6:0] seg_n
);

  // Table lookup; anything outside 0..9 stays blank
  always_comb begin
    seg_n = SEG_BLANK;
    for (int i = 0; i < 10; i++)
      if (digit == 4'(i)) seg_n = SEG_CODES[i];
  end

endmodule

// File: rtl/bcd_seg_driver.sv
// 4-digit BCD up/down counter with multiplexed seven-segment output.
// The counter steps once every STEP_DIV qualified en strobes; the display
// path registers anode, cathodes and dp together so the pins stay aligned.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits 3..1.
module bcd_seg_driver
  import seg_pkg::*;
#(
  parameter int STEP_DIV = 8,
  parameter int PRE_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [3:0]  anode,
  input  logic        run,
  input  logic        up,
  input  logic        clr,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [15:0] count_bcd,
  output logic        wrap
);

  localparam int               NUM_DIG  = 4;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

  logic [PRE_W-1:0]            pre;
  logic [NUM_DIG-1:0][3:0]     cnt, cnt_nxt;
  logic                        carry;
  logic                        step;
  logic                        anode_ok;
  logic                        blank_sel;
  bcd_digit_t                  sel_digit;
  logic [6:0]                  seg_dec;

  assign step      = en & run & (pre == PRE_LAST);
  assign count_bcd = cnt;

  // Ripple carry/borrow through the digits; carry out of digit 3 is a full wrap
  always_comb begin
    cnt_nxt = cnt;
    carry   = 1'b1;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (carry) begin
        if (up) begin
          if (cnt[i] >= 4'd9) cnt_nxt[i] = 4'd0;
          else begin
            cnt_nxt[i] = cnt[i] + 4'd1;
            carry      = 1'b0;
          end
        end else begin
          if (cnt[i] == 4'd0) cnt_nxt[i] = 4'd9;
          else begin
            cnt_nxt[i] = cnt[i] - 4'd1;
            carry      = 1'b0;
          end
        end
      end
    end
  end

  // Prescaler and counter state; clear beats step beats hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre  <= '0;
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (clr) begin
      pre  <= '0;
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= step & carry;
      if (en && run) pre <= step ? '0 : pre + 1'b1;
      if (step)      cnt <= cnt_nxt;
    end
  end

  assign anode_ok = (anode != 4'd0) && ((anode & (anode - 4'd1)) == 4'd0);

  // Digit mux; only meaningful when anode is one-hot
  always_comb begin
    sel_digit = '0;
    for (int i = 0; i < NUM_DIG; i++)
      if (anode[i]) sel_digit = cnt[i];
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIG-1:0] lead_zero;

  // A digit is a leading zero if it and every digit above it are zero;
  // the units digit is always shown
  always_comb begin
    lead_zero[NUM_DIG-1] = (cnt[NUM_DIG-1] == 4'd0);
    for (int i = NUM_DIG - 2; i >= 1; i--)
      lead_zero[i] = lead_zero[i+1] && (cnt[i] == 4'd0);
    lead_zero[0] = 1'b0;
  end

  assign blank_sel = |(anode & lead_zero);
`else
  assign blank_sel = 1'b0;
`endif

  bcd_to_seg u_dec (
    .digit (sel_digit),
    .seg_n (seg_dec)
  );

  // Display pins, registered together from the pre-edge count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n  <= ANODE_OFF;
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
    end else begin
      dp_n <= (anode != 4'b0100);
      if (anode_ok) begin
        an_n  <= ~anode;
        seg_n <= blank_sel ? SEG_BLANK : seg_dec;
      end else begin
        an_n  <= ANODE_OFF;
        seg_n <= SEG_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_bcd_seg_driver.sv
// Self-checking bench for bcd_seg_driver: directed scenarios plus random
// traffic, compared against an integer-valued reference model.
module tb_bcd_seg_driver;

  localparam int SD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, run = 1'b0, up = 1'b1, clr = 1'b0;
  logic [3:0]  anode = 4'b0000;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [15:0] count_bcd;
  logic        wrap;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int         m_cnt = 0;
  int         m_pre = 0;
  bit         m_wrap = 0;
  logic [3:0] m_an = 4'hF;
  logic [6:0] m_seg = 7'h7F;
  logic       m_dp = 1'b1;

  logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int         pow10 [4] = '{1, 10, 100, 1000};

  bcd_seg_driver #(.STEP_DIV(SD), .PRE_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .anode     (anode),
    .run       (run),
    .up        (up),
    .clr       (clr),
    .an_n      (an_n),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .count_bcd (count_bcd),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, ".cnt"},  count_bcd, to_bcd(m_cnt));
    chk({tag, ".wrap"}, wrap,      m_wrap);
    chk({tag, ".an"},   an_n,      m_an);
    chk({tag, ".seg"},  seg_n,     m_seg);
    chk({tag, ".dp"},   dp_n,      m_dp);
  endtask

  // Display expectation from the value held before the edge
  task automatic model_disp(input int old, input logic [3:0] a);
    int  idx;
    bit  blank;
    m_dp = (a != 4'b0100);
    if ($countones(a) == 1) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (a[i]) idx = i;
      blank = 0;
`ifdef LEADING_ZERO_BLANK_EN
      blank = (idx > 0) && (old < pow10[idx]);
`endif
      m_an  = ~a;
      m_seg = blank ? 7'h7F : segtab[(old / pow10[idx]) % 10];
    end else begin
      m_an  = 4'hF;
      m_seg = 7'h7F;
    end
  endtask

  // One clock: drive at negedge, check 1 time unit after the posedge
  task automatic cyc(input logic e, input logic r, input logic u, input logic c,
                     input logic [3:0] a, input string tag);
    int old;
    en = e; run = r; up = u; clr = c; anode = a;
    @(posedge clk);
    #1;
    old = m_cnt;
    model_disp(old, a);
    if (c) begin
      m_cnt = 0; m_pre = 0; m_wrap = 0;
    end else if (e && r) begin
      if (m_pre == SD - 1) begin
        m_pre = 0;
        if (u) begin
          m_wrap = (old == 9999);
          m_cnt  = (old + 1) % 10000;
        end else begin
          m_wrap = (old == 0);
          m_cnt  = (old + 9999) % 10000;
        end
      end else begin
        m_pre++;
        m_wrap = 0;
      end
    end else begin
      m_wrap = 0;
    end
    chk_all(tag);
    @(negedge clk);
  endtask

  function automatic logic [3:0] rand_anode();
    int r;
    r = $urandom_range(0, 7);
    if (r < 4) return 4'(1 << r);
    return 4'($urandom);
  endfunction

  logic [3:0] scan_an  [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [3:0] scan_ann [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic [6:0] scan_seg [4] = '{7'h79, 7'h24, 7'h30, 7'h19};

  initial begin
    // Reset state while rst_n is held low
    #12;
    chk("rst.cnt",  count_bcd, 16'h0000);
    chk("rst.wrap", wrap,      1'b0);
    chk("rst.an",   an_n,      4'hF);
    chk("rst.seg",  seg_n,     7'h7F);
    chk("rst.dp",   dp_n,      1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // 20 strobes at STEP_DIV=2 -> 10 steps
    for (int i = 0; i < 20; i++) cyc(1, 1, 1, 0, rand_anode(), "up20");
    chk("up20.value", count_bcd, 16'h0010);

    // Count to 0347, then assert reset between edges
    while (m_cnt != 347) cyc(1, 1, 1, 0, rand_anode(), "to347");
    chk("pre_areset.value", count_bcd, 16'h0347);
    #2 rst_n = 1'b0;
    #1;
    chk("areset.cnt",  count_bcd, 16'h0000);
    chk("areset.wrap", wrap,      1'b0);
    chk("areset.an",   an_n,      4'hF);
    chk("areset.seg",  seg_n,     7'h7F);
    chk("areset.dp",   dp_n,      1'b1);
    m_cnt = 0; m_pre = 0; m_wrap = 0; m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Down wrap 0000 -> 9999, then up wrap back to 0000
    cyc(1, 1, 0, 0, 4'b0001, "wdn0");
    cyc(1, 1, 0, 0, 4'b0001, "wdn1");
    chk("wrapdn.pulse", wrap, 1'b1);
    chk("wrapdn.value", count_bcd, 16'h9999);
    cyc(0, 1, 0, 0, 4'b0001, "wdn_hold");
    chk("wrapdn.once", wrap, 1'b0);
    cyc(1, 1, 1, 0, 4'b0001, "wup0");
    cyc(1, 1, 1, 0, 4'b0001, "wup1");
    chk("wrapup.pulse", wrap, 1'b1);
    chk("wrapup.value", count_bcd, 16'h0000);
    cyc(0, 1, 1, 0, 4'b0001, "wup_hold");
    chk("wrapup.once", wrap, 1'b0);

    // run=0 freezes the prescaler midway
    cyc(1, 1, 1, 0, 4'b0001, "frz0");
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0, 4'b0001, "frz");
    cyc(1, 1, 1, 0, 4'b0001, "frz1");
    chk("freeze.value", count_bcd, 16'h0001);

    // Scan pattern at 1234
    while (m_cnt != 1234) cyc(1, 1, 1, 0, rand_anode(), "to1234");
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1, 0, scan_an[i], "scan");
      chk("scan.an",  an_n,  scan_ann[i]);
      chk("scan.seg", seg_n, scan_seg[i]);
      chk("scan.dp",  dp_n,  (i == 1) ? 1'b0 : 1'b1);
    end

    // Illegal anodes
    cyc(0, 1, 1, 0, 4'b0110, "ill0110");
    chk("ill0110.an", an_n, 4'hF);
    chk("ill0110.seg", seg_n, 7'h7F);
    cyc(0, 1, 1, 0, 4'b0000, "ill0000");
    chk("ill0000.an", an_n, 4'hF);
    chk("ill0000.seg", seg_n, 7'h7F);

    // clr wins over a step on the same edge
    cyc(1, 1, 1, 0, 4'b0001, "clr_arm");
    cyc(1, 1, 1, 1, 4'b0001, "clr");
    chk("clr.value", count_bcd, 16'h0000);
    chk("clr.wrap",  wrap, 1'b0);
    cyc(1, 1, 1, 0, 4'b0001, "clr_pre");
    chk("clr.pre_zeroed", count_bcd, 16'h0000);
    cyc(1, 1, 1, 0, 4'b0001, "clr_pre2");
    chk("clr.step_after", count_bcd, 16'h0001);

    // Count to 0007 and scan all digits
    while (m_cnt != 7) cyc(1, 1, 1, 0, 4'b0001, "to7");
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1, 0, scan_an[i], "lz");
`ifdef LEADING_ZERO_BLANK_EN
      chk("lz.seg", seg_n, (i == 3) ? 7'h78 : 7'h7F);
`else
      chk("lz.seg", seg_n, (i == 3) ? 7'h78 : 7'h40);
`endif
    end

    // Random traffic
    for (int i = 0; i < 3000; i++)
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0),
          1'($urandom), 1'($urandom_range(0, 63) == 0), rand_anode(), "rnd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_seg_driver.md
Name: bcd_seg_driver

Overview:
- Display-side consumer of the rotating one-hot digit select and the periodic `en` strobe from the digit-scan generator.
- Holds a 4-digit BCD up/down counter that steps on a prescaled count of `en` strobes.
- Muxes the digit selected by the current anode and decodes it to seven-segment cathodes.
- Drives the board's active-low anode and cathode pins with registered, mutually aligned outputs.

Parameters:
- STEP_DIV, 8: number of `en` strobes per counter step; legal range 1..255.
- PRE_W, 8: prescaler width; must satisfy 2^PRE_W >= STEP_DIV.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  single-cycle strobe from the scan generator
- anode  in  4  one-hot digit select, active-high; 4'b1000 = digit 3 (thousands), 4'b0001 = digit 0 (units)
- run  in  1  counting enabled
- up  in  1  1 = count up, 0 = count down
- clr  in  1  synchronous clear of counter and prescaler
- an_n  out  4  registered anode pins, active-low
- seg_n  out  7  registered cathodes {g,f,e,d,c,b,a}, active-low
- dp_n  out  1  registered decimal point, active-low
- count_bcd  out  16  counter value, 4 BCD nibbles, digit 3 in [15:12]
- wrap  out  1  one-cycle pulse on 9999->0000 or 0000->9999

Behaviour:
- Reset (async, rst_n=0):
  - count_bcd=0, prescaler=0, wrap=0.
  - an_n=4'b1111, seg_n=7'h7F, dp_n=1.
  - Release is synchronous to the next clk edge.
- Priority each clk: clr > step > hold.
  - clr=1: count_bcd=0, prescaler=0, wrap=0 next cycle, regardless of en/run.
- Prescaler:
  - Increments only when en=1 and run=1.
  - When prescaler==STEP_DIV-1 and en=1 and run=1: prescaler reloads 0 and the counter steps in the same edge.
  - run=0 freezes the prescaler; it does not clear it.
- Counter stepping:
  - Per-nibble BCD arithmetic with a ripple carry/borrow chain within a single cycle.
  - up=1: digit 9 rolls to 0 and carries into the next digit.
  - up=0: digit 0 rolls to 9 and borrows from the next digit.
  - Full wrap (9999->0000 up, 0000->9999 down) pulses wrap=1 for exactly the cycle after the step edge.
  - Nibble values above 9 are unreachable; if forced, the decoder shows blank.
- Display path, 1-cycle latency:
  - an_n <= ~anode when anode is exactly one-hot.
  - seg_n <= decode(count_bcd nibble selected by anode) in the same edge, so pins always agree.
  - Non-one-hot anode (0000, two bits set, etc.): an_n=4'b1111, seg_n=7'h7F.
  - Uses count_bcd as registered before the current edge; a step and an anode change on the same edge show the old value for one scan slot.
- dp_n=0 only while digit 2 is selected (anode=0100), marking ss.s style; 1 otherwise.
- Decoder (active-low, {g..a}):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Values >9 give 7F.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: digits 3..1 are blanked (seg_n=7F, an_n still driven) while they and every higher digit are 0. Digit 0 is never blanked. Blanking is computed from the same registered count used for decode.
- Undefined: all digits are always displayed.

Decomposition:
- Package seg_pkg holds:
  - localparam array of the ten segment codes plus SEG_BLANK=7'h7F;
  - ANODE_OFF=4'b1111;
  - typedef bcd_digit_t as a 4-bit logic type.
- One sub-module, bcd_to_seg: combinational nibble-to-seg_n decoder that returns SEG_BLANK for values >9. It is instantiated once, after the digit mux.

Test Plan:
- Async reset: assert rst_n=0 mid-count at 0347 between clk edges -> outputs at reset values immediately with no clk edge needed; count_bcd=0.
- Up count: STEP_DIV=2, run=1, up=1, 20 en pulses from 0000 -> count_bcd=0x0010, no wrap.
- Wrap up: preload by counting to 9999 (or force), one step -> 0000 with wrap=1 for one cycle. Wrap down: 0000 with up=0, one step -> 9999 with wrap pulse.
- Scan: count=0x1234, anode sequence 1000/0100/0010/0001 -> one cycle later an_n=0111/1011/1101/1110 and seg_n=79/24/30/19; dp_n=0 only at the 1011 slot.
- Illegal anode 0110 and 0000 -> an_n=1111, seg_n=7F the next cycle.
- clr with en, run and a step all active on the same edge -> count_bcd=0, prescaler 0, no wrap. With LEADING_ZERO_BLANK_EN and count=0x0007 -> digits 3..1 show 7F, digit 0 shows 78.
